msk_mod_tx: RTL and testbench
=============================

// Module: msk_mod_tx
// PURPOSE
//  Burst MSK modulator: the transmit counterpart of the MSK RX chain.
//  - Accepts bytes on an AXI-Stream-style interface and sends them MSB-first.
//  - Each frame is PREAMBLE bits, then payload, then TAIL bits.
//  - Output is continuous-phase MSK baseband I/Q (h=0.5) at OSF samples/symbol.
//  - I/Q feeds I_in/Q_in of duc_ddc_lpf_top (DUC path).
// PARAMETERS
//  OSF        20            samples per symbol; phase LUT has 4*OSF entries
//  WO         16            signed I/Q output width
//  AMP        30000         LUT peak amplitude; must be < 2**(WO-1)
//  PRE_BITS   32            preamble length in bits, 1..32
//  PRE_PAT    32'h33333333  preamble pattern ("0011" repeat), sent MSB-first
//  TAIL_BITS  4             zero bits appended after the tlast byte
// PORTS
//  clk       in   1   system clock
//  rst       in   1   synchronous reset, active-high
//  smp_en    in   1   output-sample strobe; 1 pulse = 1 I/Q sample
//  tx_en     in   1   permits a new frame to start from IDLE
//  s_tdata   in   8   payload byte
//  s_tvalid  in   1   s_tdata valid
//  s_tlast   in   1   marks the last payload byte of the frame
//  s_tready  out  1   byte accepted when s_tvalid && s_tready
//  i_out     out  WO  signed I sample
//  q_out     out  WO  signed Q sample
//  iq_val    out  1   i_out/q_out valid (1 clk pulse)
//  sym_stb   out  1   1 clk pulse with iq_val on sample 0 of each symbol
//  busy      out  1   high in any state other than IDLE
//  underrun  out  1   1 clk pulse when a fill byte is inserted
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; idx=0; byte buffer empty.
//  Byte buffer (1 deep, holds data+last):
//   - s_tready = ~buf_vld.
//   - On s_tvalid&&s_tready the buffer captures the byte next clk.
//   - Load and unload in the same clk are allowed; s_tready stays a registered ~buf_vld.
//  FSM states: IDLE, PRE, DATA, TAIL. Transitions happen on clk unless noted.
//   - IDLE -> PRE when tx_en && buf_vld.
//     Sets idx=0, sample counter sc=0, bit counter bc=0, shift reg=PRE_PAT.
//   - PRE -> DATA after the last sample of preamble bit PRE_BITS-1.
//     Loads the byte from the buffer and clears buf_vld.
//   - In DATA, at the last sample of bit 7:
//     - if the current byte had last=1: -> TAIL;
//     - else if buf_vld: load the next byte;
//     - else load fill byte 8'h33, pulse underrun for 1 clk, stay in DATA.
//   - TAIL -> IDLE after the last sample of tail bit TAIL_BITS-1.
//     idx is then forced to 0.
//  Sample engine, on each smp_en while state != IDLE:
//   - Registered outputs, valid the next clk with iq_val=1:
//     i_out=COS[idx], q_out=SIN[idx].
//   - Phase step: idx <= (idx + (bit ? +1 : -1)) mod 4*OSF.
//     Gives exactly +/-pi/2 per symbol. Wrap 79->0 and 0->79 (OSF=20).
//   - sc increments and wraps at OSF-1. The bit advances when sc wraps.
//   - sym_stb = iq_val && (sc was 0).
//  LUT (elaboration constants):
//   - COS[k] = round(AMP*cos(2*pi*k/(4*OSF))); SIN likewise with sin.
//   - Stored in WO-bit two's complement, no saturation needed.
//  smp_en is ignored in IDLE. While IDLE, iq_val=0 and i_out/q_out hold 0.
//  Output latency: 1 clk from smp_en to iq_val.
//  tx_en deassert mid-frame has no effect. The frame always completes through TAIL.
//  smp_en on back-to-back clks is legal; every pulse produces one sample.
//  Reset mid-frame: everything returns to reset state on the next clk,
//  and any byte held in the buffer is dropped.
//  s_tlast with no frame active is only latched. It is acted on when that byte is sent.
// TESTING
//  1. rst=1 for 4 clks -> all outputs 0, s_tready=1 after release.
//  2. One byte 8'hA5 with tlast, tx_en=1, smp_en every clk:
//     - busy for (32+8+4)*20 = 880 samples, then IDLE;
//     - first sample I=30000, Q=0; 44 sym_stb pulses.
//  3. PRE_PAT bits 0,0,1,1: after 40 samples idx=80-40=40, then back to 0 after 80 samples.
//     Check I=-30000 at sample 40 and wrap 0->79 on the first step.
//  4. Bytes 01,02 with no third byte and no tlast -> underrun pulses once,
//     fill byte 0x33 is sent, and the frame continues.
//  5. smp_en every 10 clks with a 4-byte frame:
//     - iq_val spacing is 10 clks;
//     - s_tready never drops twice before the bit-7 boundary;
//     - no byte is lost (compare against msk_slicer_dec_mdl via the loopback bench).
//  6. rst asserted at sample 300 of a frame -> next clk busy=0, iq_val=0, buffer empty;
//     a new frame restarts with I=30000.

Source files
------------

// File: rtl/msk_mod_tx.sv
// msk_mod_tx: burst MSK modulator, AXI-Stream bytes in, continuous-phase I/Q out.
// Frame = preamble, payload bytes MSB-first, zero tail; h=0.5, OSF samples/symbol.
module msk_mod_tx #(
   parameter int          OSF       = 20,
   parameter int          WO        = 16,
   parameter int          AMP       = 30000,
   parameter int          PRE_BITS  = 32,
   parameter logic [31:0] PRE_PAT   = 32'h33333333,
   parameter int          TAIL_BITS = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          smp_en,
   input  logic          tx_en,
   input  logic [7:0]    s_tdata,
   input  logic          s_tvalid,
   input  logic          s_tlast,
   output logic          s_tready,
   output logic [WO-1:0] i_out,
   output logic [WO-1:0] q_out,
   output logic          iq_val,
   output logic          sym_stb,
   output logic          busy,
   output logic          underrun
);
   localparam int  NPH = 4 * OSF;
   localparam int  IW  = $clog2(NPH);
   localparam int  SW  = $clog2(OSF + 1);
   localparam int  BW  = 6;
   localparam real PI  = 3.14159265358979323846;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PRE  = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_TAIL = 2'd3;

   function automatic logic [WO-1:0] lut(input int k, input logic sn);
      real a;
      real v;
      a = 2.0 * PI * real'(k) / real'(NPH);
      v = real'(AMP) * (sn ? $sin(a) : $cos(a));
      return WO'(v >= 0.0 ? $rtoi(v + 0.5) : $rtoi(v - 0.5));
   endfunction

   logic [WO-1:0] cos_tab [NPH];
   logic [WO-1:0] sin_tab [NPH];

   for (genvar k = 0; k < NPH; k++) begin : g_lut
      assign cos_tab[k] = lut(k, 1'b0);
      assign sin_tab[k] = lut(k, 1'b1);
   end

   logic [1:0]    state;
   logic [IW-1:0] idx;
   logic [SW-1:0] sc;
   logic [BW-1:0] bc;
   logic [31:0]   shreg;
   logic          cur_last;
   logic [7:0]    buf_data;
   logic          buf_last;
   logic          buf_vld;

   logic          sc_last;
   logic          pre_end;
   logic          data_end;
   logic          data_last;
   logic          data_next;
   logic          data_fill;
   logic          tail_end;
   logic          load;
   logic          unload;
   logic          buf_vld_n;
   logic [IW-1:0] idx_nx;

   // bit boundaries only count on a sample strobe, so they fold in smp_en
   always_comb begin
      sc_last   = (sc == SW'(OSF - 1));
      pre_end   = smp_en && sc_last && (state == S_PRE)
                  && (bc == BW'(PRE_BITS - 1));
      data_end  = smp_en && sc_last && (state == S_DATA)
                  && (bc == BW'(7));
      data_last = data_end && cur_last;
      data_next = data_end && !cur_last && buf_vld;
      data_fill = data_end && !cur_last && !buf_vld;
      tail_end  = smp_en && sc_last && (state == S_TAIL)
                  && (bc == BW'(TAIL_BITS - 1));
      load      = s_tvalid && s_tready;
      unload    = pre_end || data_next;
      buf_vld_n = (buf_vld && !unload) || load;
      if (shreg[31])
         idx_nx = (idx == IW'(NPH - 1)) ? '0 : idx + 1'b1;
      else
         idx_nx = (idx == '0) ? IW'(NPH - 1) : idx - 1'b1;
   end

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         idx      <= '0;
         sc       <= '0;
         bc       <= '0;
         shreg    <= '0;
         cur_last <= 1'b0;
         buf_data <= '0;
         buf_last <= 1'b0;
         buf_vld  <= 1'b0;
         s_tready <= 1'b0;
         i_out    <= '0;
         q_out    <= '0;
         iq_val   <= 1'b0;
         sym_stb  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         iq_val   <= 1'b0;
         sym_stb  <= 1'b0;
         underrun <= 1'b0;
         buf_vld  <= buf_vld_n;
         s_tready <= ~buf_vld_n;
         if (load) begin
            buf_data <= s_tdata;
            buf_last <= s_tlast;
         end
         if (state == S_IDLE) begin
            i_out <= '0;
            q_out <= '0;
            if (tx_en && buf_vld) begin
               state <= S_PRE;
               idx   <= '0;
               sc    <= '0;
               bc    <= '0;
               shreg <= PRE_PAT << (32 - PRE_BITS);
            end
         end else if (smp_en) begin
            i_out   <= cos_tab[idx];
            q_out   <= sin_tab[idx];
            iq_val  <= 1'b1;
            sym_stb <= (sc == '0);
            idx     <= tail_end ? '0 : idx_nx;
            sc      <= sc_last ? '0 : sc + 1'b1;
            if (sc_last) begin
               bc    <= bc + 1'b1;
               shreg <= {shreg[30:0], 1'b0};
            end
            unique case (1'b1)
               pre_end: begin
                  state    <= S_DATA;
                  bc       <= '0;
                  shreg    <= {buf_data, 24'd0};
                  cur_last <= buf_last;
               end
               data_last: begin
                  state <= S_TAIL;
                  bc    <= '0;
                  shreg <= '0;
               end
               data_next: begin
                  bc       <= '0;
                  shreg    <= {buf_data, 24'd0};
                  cur_last <= buf_last;
               end
               data_fill: begin
                  bc       <= '0;
                  shreg    <= {8'h33, 24'd0};
                  cur_last <= 1'b0;
                  underrun <= 1'b1;
               end
               tail_end: state <= S_IDLE;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_msk_mod_tx.sv
// tb_msk_mod_tx: random frames against a bit-list/phase-walk MSK reference.
// Samples are collected on negedge and compared per frame after busy falls.
module tb_msk_mod_tx;
   localparam real PI = 3.14159265358979323846;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        smp_en = 1'b0;
   logic        tx_en = 1'b0;
   logic [7:0]  s_tdata = 8'd0;
   logic        s_tvalid = 1'b0;
   logic        s_tlast = 1'b0;
   logic        s_tready;
   logic [15:0] i_out;
   logic [15:0] q_out;
   logic        iq_val;
   logic        sym_stb;
   logic        busy;
   logic        underrun;

   int n_chk = 0;
   int n_pass = 0;
   int smp_div = 1;
   int cyc = 0;
   int ur_cnt = 0;
   int lat_err = 0;
   logic p_smp = 1'b0;
   logic p_busy = 1'b0;
   logic p_rst = 1'b1;
   logic [31:0] pre_pat = 32'h33333333;

   logic [31:0] smp_q[$];
   bit          stb_q[$];
   int          cyc_q[$];

   msk_mod_tx dut (
      .clk(clk), .rst(rst), .smp_en(smp_en), .tx_en(tx_en),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
      .s_tready(s_tready), .i_out(i_out), .q_out(q_out),
      .iq_val(iq_val), .sym_stb(sym_stb), .busy(busy),
      .underrun(underrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      p_smp  <= smp_en;
      p_busy <= busy;
      p_rst  <= rst;
   end

   always @(negedge clk) begin
      if (!rst && !p_rst) begin
         if (iq_val !== (p_smp & p_busy)) lat_err++;
         if (sym_stb && !iq_val) lat_err++;
         if (underrun) ur_cnt++;
         if (iq_val) begin
            smp_q.push_back({i_out, q_out});
            stb_q.push_back(sym_stb);
            cyc_q.push_back(cyc);
         end
      end
   end

   initial begin
      int c = 0;
      forever begin
         @(negedge clk);
         if (smp_div == 0) begin
            smp_en = 1'($urandom_range(0, 1));
         end else begin
            smp_en = (c == 0);
            c = (c + 1 >= smp_div) ? 0 : c + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   function automatic int rnd(input real v);
      return int'($floor(v + 0.5));
   endfunction

   task automatic push(input logic [7:0] d, input logic l);
      int n = 0;
      s_tdata  = d;
      s_tlast  = l;
      s_tvalid = 1'b1;
      while (!s_tready && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) chk("push_timeout", 32'd0, 32'd1);
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic wait_frame();
      int n = 0;
      while (!busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("busy_rise", 32'(busy), 32'd1);
      n = 0;
      while (busy && n < 40000) begin
         @(negedge clk);
         n++;
      end
      chk("busy_fall", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      chk("idle_iq", {i_out, q_out}, 32'd0);
      chk("idle_val", 32'(iq_val), 32'd0);
   endtask

   // expected bits -> phase walk of +/-1 quarter-step per sample, mod 80
   task automatic check_frame(input string nm, input int base,
                              input logic [7:0] b[$]);
      bit  bits[$];
      int  ph = 0;
      int  n = 0;
      int  ei;
      int  eq;
      real a;
      for (int k = 31; k >= 0; k--) bits.push_back(pre_pat[k]);
      foreach (b[j])
         for (int k = 7; k >= 0; k--) bits.push_back(b[j][k]);
      repeat (4) bits.push_back(1'b0);
      chk({nm, "_nsmp"}, 32'(smp_q.size() - base), 32'(bits.size() * 20));
      foreach (bits[j]) begin
         for (int s = 0; s < 20; s++) begin
            if (base + n < smp_q.size()) begin
               a  = 2.0 * PI * real'(ph) / 80.0;
               ei = rnd(30000.0 * $cos(a));
               eq = rnd(30000.0 * $sin(a));
               chk($sformatf("%s_iq%0d", nm, n), smp_q[base + n],
                   {16'(ei), 16'(eq)});
               chk($sformatf("%s_stb%0d", nm, n), 32'(stb_q[base + n]),
                   32'(s == 0));
            end
            n++;
            ph = bits[j] ? (ph + 1) % 80 : (ph + 79) % 80;
         end
      end
   endtask

   initial begin
      logic [7:0]  fq[$];
      logic [15:0] na;
      int base;
      int ur0;
      int cnt;
      int n;
      na = 16'(-30000);

      repeat (4) @(negedge clk);
      chk("rst_iq", {i_out, q_out}, 32'd0);
      chk("rst_flags", {27'd0, busy, iq_val, sym_stb, underrun, s_tready},
          32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("tready_rel", 32'(s_tready), 32'd1);

      // single byte, smp_en every clk
      smp_div = 1;
      tx_en = 1'b1;
      base = smp_q.size();
      ur0 = ur_cnt;
      push(8'hA5, 1'b1);
      wait_frame();
      fq.delete();
      fq.push_back(8'hA5);
      check_frame("t2", base, fq);
      chk("t2_i0", {16'd0, smp_q[base][31:16]}, 32'd30000);
      chk("t2_q1_neg", 32'(smp_q[base + 1][15]), 32'd1);
      chk("t2_i40", {16'd0, smp_q[base + 40][31:16]}, {16'd0, na});
      chk("t2_i80", {16'd0, smp_q[base + 80][31:16]}, 32'd30000);
      cnt = 0;
      for (int k = base; k < stb_q.size(); k++) cnt += int'(stb_q[k]);
      chk("t2_stb_cnt", 32'(cnt), 32'd44);
      chk("t2_ur", 32'(ur_cnt - ur0), 32'd0);

      // underrun: fill byte 0x33 inserted after 02
      base = smp_q.size();
      ur0 = ur_cnt;
      push(8'h01, 1'b0);
      push(8'h02, 1'b0);
      n = 0;
      while (ur_cnt == ur0 && n < 10000) begin
         @(negedge clk);
         n++;
      end
      chk("t4_ur_seen", 32'(ur_cnt - ur0), 32'd1);
      push(8'h03, 1'b1);
      wait_frame();
      fq.delete();
      fq.push_back(8'h01);
      fq.push_back(8'h02);
      fq.push_back(8'h33);
      fq.push_back(8'h03);
      check_frame("t4", base, fq);
      chk("t4_ur", 32'(ur_cnt - ur0), 32'd1);

      // smp_en every 10 clks, 4 random bytes
      smp_div = 10;
      base = smp_q.size();
      ur0 = ur_cnt;
      fq.delete();
      for (int k = 0; k < 4; k++) fq.push_back(8'($urandom));
      foreach (fq[k]) push(fq[k], k == 3);
      wait_frame();
      check_frame("t5", base, fq);
      cnt = 0;
      for (int k = base + 1; k < cyc_q.size(); k++)
         if (cyc_q[k] - cyc_q[k - 1] != 10) cnt++;
      chk("t5_spacing", 32'(cnt), 32'd0);
      chk("t5_ur", 32'(ur_cnt - ur0), 32'd0);

      // random strobes, random lengths, tx_en dropped mid-frame
      smp_div = 0;
      for (int f = 0; f < 3; f++) begin
         base = smp_q.size();
         ur0 = ur_cnt;
         tx_en = 1'b1;
         fq.delete();
         n = $urandom_range(1, 3);
         for (int k = 0; k < n; k++) fq.push_back(8'($urandom));
         push(fq[0], n == 1);
         cnt = 0;
         while (!busy && cnt < 20) begin
            @(negedge clk);
            cnt++;
         end
         tx_en = 1'b0;
         for (int k = 1; k < n; k++) push(fq[k], k == n - 1);
         wait_frame();
         check_frame($sformatf("r%0d", f), base, fq);
         chk("r_ur", 32'(ur_cnt - ur0), 32'd0);
      end

      // reset mid-frame drops the buffered byte
      smp_div = 1;
      tx_en = 1'b1;
      base = smp_q.size();
      push(8'hC3, 1'b1);
      n = 0;
      while (smp_q.size() - base < 300 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("t6_reach300", 32'(smp_q.size() - base >= 300), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_flags", {28'd0, busy, iq_val, sym_stb, underrun},
          32'd0);
      chk("t6_rst_iq", {i_out, q_out}, 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("t6_idle", 32'(busy), 32'd0);
      chk("t6_tready", 32'(s_tready), 32'd1);
      base = smp_q.size();
      push(8'h5A, 1'b1);
      wait_frame();
      fq.delete();
      fq.push_back(8'h5A);
      check_frame("t6", base, fq);
      chk("t6_i0", {16'd0, smp_q[base][31:16]}, 32'd30000);

      chk("latency", 32'(lat_err), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
